rf_param: RTL and testbench



---
 rtl/rf_param.sv | 122 ++++++++++++
 tb/tb_rf_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rf_param.sv
//==============================================================================
// Module   : rf_param
// Brief    : Parametrised register file, two combinational read ports, one
//            write port, post-reset sequential clear and a sticky error flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int SELW   = 3,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SELW-1:0]  read1regsel,
    input  logic [SELW-1:0]  read2regsel,
    input  logic [SELW-1:0]  writeregsel,
    input  logic [WIDTH-1:0] writedata,
    input  logic             write,
    output logic [WIDTH-1:0] read1data,
    output logic [WIDTH-1:0] read2data,
    output logic             ready,
    output logic             err
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [SELW-1:0] c_LAST  = SELW'(DEPTH - 1);
    localparam logic [SELW:0]   c_DEPTH = (SELW + 1)'(DEPTH);

    state_t            r_state;
    logic [SELW-1:0]   r_ptr;
    logic              r_ready;
    logic              r_err;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_wr_in_range;
    logic              w_wr_ok;
    logic              w_byp_en;
    logic [WIDTH-1:0]  w_rd1;
    logic [WIDTH-1:0]  w_rd2;

    assign w_wr_in_range = ({1'b0, writeregsel} < c_DEPTH);
    assign w_wr_ok       = write && (r_state == ST_RUN) && w_wr_in_range;

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_byp_en = w_wr_ok;
        end else begin : g_no_bypass
            assign w_byp_en = 1'b0;
        end
    endgenerate

    // Control FSM: the clear pointer walks every entry once before RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_ptr <= r_ptr + 1'b1;
            if (write) begin
                r_err <= 1'b1;
            end
            if (r_ptr == c_LAST) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end else begin
            if (write && !w_wr_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage is never reset directly; the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_ok) begin
                r_mem[writeregsel] <= writedata;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        if (r_state == ST_RUN) begin
            if (w_byp_en && (read1regsel == writeregsel)) begin
                w_rd1 = writedata;
            end else if ({1'b0, read1regsel} < c_DEPTH) begin
                w_rd1 = r_mem[read1regsel];
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (r_state == ST_RUN) begin
            if (w_byp_en && (read2regsel == writeregsel)) begin
                w_rd2 = writedata;
            end else if ({1'b0, read2regsel} < c_DEPTH) begin
                w_rd2 = r_mem[read2regsel];
            end
        end
    end

    assign read1data = w_rd1;
    assign read2data = w_rd2;
    assign ready     = r_ready;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_param.sv
//==============================================================================
// Module   : tb_rf_param
// Brief    : Randomised self-checking bench for rf_param in three configurations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rf_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Per-configuration stimulus: 0 = 16x8 bypass, 1 = 16x6 no bypass, 2 = 32x16 bypass
    logic [31:0] s_r1 [3];
    logic [31:0] s_r2 [3];
    logic [31:0] s_w  [3];
    logic [31:0] s_wd [3];
    logic        s_we [3];

    logic [15:0] a_q1, a_q2, b_q1, b_q2;
    logic [31:0] c_q1, c_q2;
    logic        a_rdy, a_err, b_rdy, b_err, c_rdy, c_err;

    rf_param #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst),
        .read1regsel(s_r1[0][2:0]), .read2regsel(s_r2[0][2:0]),
        .writeregsel(s_w[0][2:0]), .writedata(s_wd[0][15:0]), .write(s_we[0]),
        .read1data(a_q1), .read2data(a_q2), .ready(a_rdy), .err(a_err)
    );

    rf_param #(.WIDTH(16), .DEPTH(6), .SELW(3), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst),
        .read1regsel(s_r1[1][2:0]), .read2regsel(s_r2[1][2:0]),
        .writeregsel(s_w[1][2:0]), .writedata(s_wd[1][15:0]), .write(s_we[1]),
        .read1data(b_q1), .read2data(b_q2), .ready(b_rdy), .err(b_err)
    );

    rf_param #(.WIDTH(32), .DEPTH(16), .SELW(4), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst),
        .read1regsel(s_r1[2][3:0]), .read2regsel(s_r2[2][3:0]),
        .writeregsel(s_w[2][3:0]), .writedata(s_wd[2]), .write(s_we[2]),
        .read1data(c_q1), .read2data(c_q2), .ready(c_rdy), .err(c_err)
    );

    // Reference model: architectural view only (contents, ready, err)
    int          c_depth  [3] = '{8, 6, 16};
    bit          c_byp    [3] = '{1'b1, 1'b0, 1'b1};
    int          c_selmax [3] = '{7, 7, 15};
    logic [31:0] c_wmask  [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};

    logic [31:0] m_mem [3][16];
    bit          m_rdy [3];
    bit          m_err [3];
    int          m_cnt [3];
    bit          m_valid;
    bit          quiet_init;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k, input logic [31:0] rs);
        if (!m_rdy[k]) return 32'h0;
        if (c_byp[k] && s_we[k] && (s_w[k] < c_depth[k]) && (rs == s_w[k])) return s_wd[k];
        if (rs < c_depth[k]) return m_mem[k][rs];
        return 32'h0;
    endfunction

    function automatic logic [31:0] got_val(input int k, input int what);
        case (k)
            0: case (what) 0: return {16'h0, a_q1}; 1: return {16'h0, a_q2};
                           2: return {31'h0, a_rdy}; default: return {31'h0, a_err}; endcase
            1: case (what) 0: return {16'h0, b_q1}; 1: return {16'h0, b_q2};
                           2: return {31'h0, b_rdy}; default: return {31'h0, b_err}; endcase
            default: case (what) 0: return c_q1; 1: return c_q2;
                                 2: return {31'h0, c_rdy}; default: return {31'h0, c_err}; endcase
        endcase
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_rdy[k] = 1'b0;
                m_err[k] = 1'b0;
                m_cnt[k] = 0;
                for (int e = 0; e < 16; e++) m_mem[k][e] = 32'h0;
            end else if (!m_rdy[k]) begin
                if (s_we[k]) m_err[k] = 1'b1;
                m_cnt[k]++;
                if (m_cnt[k] == c_depth[k]) m_rdy[k] = 1'b1;
            end else if (s_we[k]) begin
                if (s_w[k] < c_depth[k]) m_mem[k][s_w[k]] = s_wd[k];
                else m_err[k] = 1'b1;
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    // Inputs are set on the falling edge; outputs checked 1 time unit later.
    task automatic cycle();
        #1;
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("d%0d.ready", k), got_val(k, 2), {31'h0, m_rdy[k]});
                chk($sformatf("d%0d.err", k),   got_val(k, 3), {31'h0, m_err[k]});
                chk($sformatf("d%0d.rd1", k),   got_val(k, 0), exp_rd(k, s_r1[k]));
                chk($sformatf("d%0d.rd2", k),   got_val(k, 1), exp_rd(k, s_r2[k]));
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input int k, input logic we, input logic [31:0] w,
                          input logic [31:0] wd, input logic [31:0] r1, input logic [31:0] r2);
        s_we[k] = we; s_w[k] = w; s_wd[k] = wd; s_r1[k] = r1; s_r2[k] = r2;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 0, 0, $urandom_range(0, c_selmax[k]),
                                           $urandom_range(0, c_selmax[k]));
    endtask

    task automatic rand_in();
        for (int k = 0; k < 3; k++) begin
            s_w[k]  = $urandom_range(0, c_selmax[k]);
            s_wd[k] = $urandom & c_wmask[k];
            s_we[k] = ($urandom_range(0, 2) == 0) && !(quiet_init && !m_rdy[k]);
            s_r1[k] = ($urandom_range(0, 3) == 0) ? s_w[k] : $urandom_range(0, c_selmax[k]);
            s_r2[k] = ($urandom_range(0, 3) == 0) ? s_w[k] : $urandom_range(0, c_selmax[k]);
        end
    endtask

    initial begin
        m_valid = 1'b0;
        quiet_init = 1'b1;
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Directed: clear sequence with reads across all selects
        for (int i = 0; i < 17; i++) begin
            idle_all();
            cycle();
        end
        set_in(0, 1'b1, 3, 32'hBEEF, 3, 5);
        set_in(2, 1'b1, 15, 32'hDEADBEEF, 15, 0);
        cycle();
        set_in(0, 1'b1, 5, 32'h1234, 3, 5);
        set_in(2, 1'b1, 0, 32'hCAFEF00D, 15, 0);
        cycle();
        set_in(0, 1'b1, 2, 32'hA5A5, 2, 2);
        set_in(1, 1'b1, 2, 32'hA5A5, 2, 2);
        set_in(2, 1'b0, 0, 0, 15, 0);
        cycle();
        set_in(0, 1'b0, 0, 0, 2, 7);
        set_in(1, 1'b1, 6, 32'h5555, 2, 7);
        cycle();
        set_in(1, 1'b0, 0, 0, 6, 7);
        cycle();
        cycle();

        // Randomised phase with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                quiet_init = ($urandom_range(0, 1) == 0);
            end else begin
                rst = 1'b0;
            end
            cycle();
        end

        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
